// File: rtl/rop3_stream.sv
// rop3_stream -- streaming ROP3 raster engine.
//
// Purpose:
//   Takes Pattern, Source and Destination words one after another on a
//   single bitmap bus with a valid/ready handshake. When the D word arrives,
//   each result bit is looked up in the 8-bit ROP3 mode, using {P,S,D} as
//   the index. The result is pushed into a small FIFO that drains to the
//   write-back stage under downstream backpressure.
//
// Parameters:
//   N      bitmap word / result width
//   DEPTH  result FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   clr              synchronous clear: FSM back to LOAD_P, FIFO emptied
//   in_valid/ready   bitmap beat handshake
//   in_data          bitmap word, P then S then D
//   in_mode          ROP3 mode, sampled on the P beat only
//   out_valid/ready  result handshake (out_valid = FIFO non-empty)
//   out_data         result at the FIFO head
//   level            FIFO occupancy
//   busy             operation in progress or results still queued
//   op_count         (only with ROP3_OPCNT_EN) count of accepted D beats
//
// Optional feature:
//   Define ROP3_OPCNT_EN to add the 16-bit op_count output.

module rop3_stream #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic [7:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic [$clog2(DEPTH):0]  level,
`ifdef ROP3_OPCNT_EN
  output logic                    busy,
  output logic [15:0]             op_count
`else
  output logic                    busy
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  localparam logic [1:0] LOAD_P = 2'd0;
  localparam logic [1:0] LOAD_S = 2'd1;
  localparam logic [1:0] LOAD_D = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    mode_q, mode_d;
  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
`ifdef ROP3_OPCNT_EN
  logic [15:0]   op_cnt_q, op_cnt_d;
`endif

  logic [N-1:0]  result;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

  // Bitwise ROP3: each output bit selects one mode bit, indexed by {P,S,D}.
  always_comb begin
    result = '0;
    for (int i = 0; i < N; i++) begin
      result[i] = mode_q[{p_q[i], s_q[i], in_data[i]}];
    end
  end

  // Full is taken from the registered level, so a pop in the same cycle
  // does not open a slot for the D beat.
  assign full      = (level_q == FULL_LEVEL);
  assign in_ready  = !clr && ((state_q != LOAD_D) || !full);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (state_q == LOAD_D);
  assign pop       = (level_q != '0) && out_ready && !clr;

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign busy      = (state_q != LOAD_P) || (level_q != '0);
`ifdef ROP3_OPCNT_EN
  assign op_count  = op_cnt_q;
`endif

  // Next-state logic. clr wins over everything. The mode, P and S registers
  // keep their contents on clr; only sequencing and the queue restart.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    p_d      = p_q;
    s_d      = s_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
`ifdef ROP3_OPCNT_EN
    op_cnt_d = op_cnt_q;
`endif
    if (clr) begin
      state_d  = LOAD_P;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
`ifdef ROP3_OPCNT_EN
      op_cnt_d = '0;
`endif
    end else begin
      if (accept) begin
        case (state_q)
          LOAD_P: begin
            p_d     = in_data;
            mode_d  = in_mode;
            state_d = LOAD_S;
          end
          LOAD_S: begin
            s_d     = in_data;
            state_d = LOAD_D;
          end
          default: state_d = LOAD_P;
        endcase
      end
      if (push) begin
        mem_d[wr_ptr_q] = result;
        wr_ptr_d        = wr_ptr_q + PW'(1);
`ifdef ROP3_OPCNT_EN
        op_cnt_d        = op_cnt_q + 16'd1;
`endif
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State registers; the FIFO storage is reset too so out_data reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_P;
      mode_q   <= '0;
      p_q      <= '0;
      s_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
`ifdef ROP3_OPCNT_EN
      op_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      p_q      <= p_d;
      s_q      <= s_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
`ifdef ROP3_OPCNT_EN
      op_cnt_q <= op_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rop3_stream.sv
// tb_rop3_stream -- self-checking bench for rop3_stream (N=8, DEPTH=4).
//
// Purpose:
//   Table-driven directed vectors, hand-written multi-cycle corner cases
//   (backpressure, mid-operation reset, clear against a D beat) and a
//   randomized run. A transaction-level reference model (phase counter,
//   result queue, minterm-based ROP3) runs alongside every cycle.
//
// Ports: none (top-level bench). Honours ROP3_OPCNT_EN like the design.

module tb_rop3_stream;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  level;
  logic        busy;
`ifdef ROP3_OPCNT_EN
  logic [15:0] op_count;
`endif

  rop3_stream #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
`ifdef ROP3_OPCNT_EN
    .busy      (busy),
    .op_count  (op_count)
`else
    .busy      (busy)
`endif
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state: which word comes next, the latched operands,
  // and the queue of results the FIFO should hold.
  int          m_phase;
  logic [7:0]  m_mode;
  logic [7:0]  m_p;
  logic [7:0]  m_s;
  logic [7:0]  m_q[$];
  logic [15:0] m_cnt;
  logic        last_ready;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [7:0] mode;
    logic       ordy;
    logic       exp_rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs[11];

  // ROP3 as a sum of minterms: mode bit k enables the minterm of P,S,D
  // selected by the bits of k (bit2=P, bit1=S, bit0=D).
  function automatic logic [7:0] ropRef(input logic [7:0] m, p, s, d);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        r = r | (((k & 4) != 0 ? p : ~p) &
                 ((k & 2) != 0 ? s : ~s) &
                 ((k & 1) != 0 ? d : ~d));
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_phase = 0;
    m_mode  = 8'h00;
    m_p     = 8'h00;
    m_s     = 8'h00;
    m_q.delete();
    m_cnt   = 16'h0000;
  endtask

  task automatic checkModelOutputs();
    checkOutput("model_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    checkOutput("model_level", 32'(level), 32'(m_q.size()));
    checkOutput("model_busy", 32'(busy),
                32'((m_phase != 0) || (m_q.size() != 0)));
    if (m_q.size() != 0) checkOutput("model_out_data", 32'(out_data), 32'(m_q[0]));
`ifdef ROP3_OPCNT_EN
    checkOutput("model_op_count", 32'(op_count), 32'(m_cnt));
`endif
  endtask

  // One clock cycle: drive inputs just after the falling edge, check
  // in_ready, advance the model across the rising edge, then check outputs
  // on the next falling edge.
  task automatic applyStimulus(input logic c, input logic v,
                               input logic [7:0] d, input logic [7:0] m,
                               input logic r);
    logic exp_rdy;
    logic acc;
    logic pop;
    clr       = c;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    #1;
    exp_rdy = !c && ((m_phase != 2) || (m_q.size() < DEPTH));
    checkOutput("model_in_ready", 32'(in_ready), 32'(exp_rdy));
    last_ready = in_ready;
    acc = v && exp_rdy;
    pop = !c && (m_q.size() != 0) && r;
    @(posedge clk);
    if (c) begin
      m_phase = 0;
      m_q.delete();
      m_cnt = 16'h0000;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        case (m_phase)
          0: begin m_mode = m; m_p = d; end
          1: m_s = d;
          default: begin
            m_q.push_back(ropRef(m_mode, m_p, m_s, d));
            m_cnt = m_cnt + 16'd1;
          end
        endcase
        m_phase = (m_phase + 1) % 3;
      end
    end
    @(negedge clk);
    checkModelOutputs();
  endtask

  task automatic doOp(input logic [7:0] m, p, s, d, input logic r);
    applyStimulus(1'b0, 1'b1, p, m, r);
    applyStimulus(1'b0, 1'b1, s, 8'h00, r);
    applyStimulus(1'b0, 1'b1, d, 8'h00, r);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_mode = 8'h00; out_ready = 1'b0; last_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_level", 32'(level), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_out_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: single op with mode 0xCC, then back-to-back 0x66/0x5A.
    vecs[0]  = '{1'b1, 8'h0F, 8'hCC, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[2]  = '{1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[4]  = '{1'b1, 8'h0F, 8'h66, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[5]  = '{1'b1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[6]  = '{1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 3'd1};
    vecs[7]  = '{1'b1, 8'h0F, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[8]  = '{1'b1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[9]  = '{1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd1};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, vecs[i].vld, vecs[i].data, vecs[i].mode, vecs[i].ordy);
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(last_ready), 32'(vecs[i].exp_rdy));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      if (vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Backpressure: four results fill the FIFO, the fifth D beat must wait
    // until a pop has been registered.
    for (int k = 1; k <= 4; k++) doOp(8'hF0, 8'(k), 8'h00, 8'h00, 1'b0);
    checkOutput("bp_level_full", 32'(level), 32'd4);
    applyStimulus(1'b0, 1'b1, 8'h05, 8'hF0, 1'b0);
    checkOutput("bp_p_ready", 32'(last_ready), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("bp_s_ready", 32'(last_ready), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("bp_d_blocked", 32'(last_ready), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    checkOutput("bp_d_blocked_on_pop", 32'(last_ready), 32'h0);
    checkOutput("bp_level_after_pop", 32'(level), 32'd3);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("bp_d_accepted", 32'(last_ready), 32'h1);
    checkOutput("bp_level_refill", 32'(level), 32'd4);
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("bp_drain%0d", k), 32'(out_data), 32'(k));
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    end
    checkOutput("bp_drained_level", 32'(level), 32'd0);

    // Mid-operation reset with one result queued and P/S already taken.
    doOp(8'hCC, 8'h00, 8'h77, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h3C, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    doOp(8'hF0, 8'h12, 8'h34, 8'h56, 1'b0);
    checkOutput("rst_next_valid", 32'(out_valid), 32'h1);
    checkOutput("rst_next_data", 32'(out_data), 32'h12);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // clr on the cycle a D beat is offered.
    applyStimulus(1'b0, 1'b1, 8'hAA, 8'hCC, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hBB, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h11, 8'h00, 1'b1);
    checkOutput("clr_in_ready", 32'(last_ready), 32'h0);
    checkOutput("clr_level", 32'(level), 32'h0);
    checkOutput("clr_busy", 32'(busy), 32'h0);
    doOp(8'hAA, 8'h01, 8'h02, 8'h5C, 1'b0);
    checkOutput("clr_next_data", 32'(out_data), 32'h5C);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

`ifdef ROP3_OPCNT_EN
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) doOp(8'h66, 8'(k), 8'h0F, 8'hF0, 1'b1);
    checkOutput("opcnt_three", 32'(op_count), 32'd3);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("opcnt_clr", 32'(op_count), 32'd0);
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("final_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
